// File: rtl/ks8_add_arbiter_pkg.sv
// Shared constants and helpers for the ks8_add_arbiter slice: the adder width,
// the operand record carried through the pipeline, and the carry-out expression.
package ks8_add_arbiter_pkg;

  localparam int NREQ_MAX = 8;
  localparam int ADD_W    = 8;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
  } operands_t;

  typedef struct packed {
    logic [ADD_W-1:0] sum;
    logic             cout;
  } result_t;

  // Carry out of the MSB, recovered from the operand MSBs and the sum MSB.
  function automatic logic carry_out(input logic a7, input logic b7, input logic s7);
    return (a7 & b7) | ((a7 | b7) & ~s7);
  endfunction

endpackage

// File: rtl/kogg_stone_8.sv
// 8-bit Kogge-Stone parallel-prefix adder with no carry-in. The sum is purely
// combinational; the carry-out is recovered by the caller from the MSBs.
module kogg_stone_8
  import ks8_add_arbiter_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] s
);

  logic [ADD_W-1:0] g0, p0;
  logic [ADD_W-1:0] g1, p1;
  logic [ADD_W-1:0] g2, p2;
  logic [ADD_W-1:0] g3;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Prefix levels at spans 1, 2 and 4. The left shifts feed zeros in below bit
  // 0, which is exactly the behaviour of a zero carry-in.
  assign g1 = g0 | (p0 & (g0 << 1));
  assign p1 = p0 & (p0 << 1);
  assign g2 = g1 | (p1 & (g1 << 2));
  assign p2 = p1 & (p1 << 2);
  assign g3 = g2 | (p2 & (g2 << 4));

  // g3[i] is the carry out of bit i, so bit i+1 sees it as its carry in.
  assign s = p0 ^ (g3 << 1);

endmodule

// File: rtl/ks8_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or above rr_ptr,
// wrapping modulo NREQ, and reports it both one-hot and encoded.
module rr_arbiter
  import ks8_add_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output and local gets a value before the loop, so no path
    // through this block leaves anything unassigned and no latch is inferred.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/ks8_add_arbiter.sv
// Shares one kogg_stone_8 adder among NREQ requesters through a round-robin
// grant and a two-stage (operand, result) valid/ready pipeline.
module ks8_add_arbiter
  import ks8_add_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [ADD_W*NREQ-1:0] req_a,
  input  logic [ADD_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  logic            op_vld_q,  op_vld_d;
  operands_t       op_q,      op_d;
  logic [IDW-1:0]  op_id_q,   op_id_d;
  logic            res_vld_q, res_vld_d;
  result_t         res_q,     res_d;
  logic [IDW-1:0]  res_id_q,  res_id_d;
  logic [IDW-1:0]  rr_ptr_q,  rr_ptr_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   winner;
  logic [ADD_W-1:0] sum;
  logic             adv;
  logic             can_load;
  logic             accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .winner    (winner)
  );

  kogg_stone_8 u_add (
    .a (op_q.a),
    .b (op_q.b),
    .s (sum)
  );

  assign adv      = op_vld_q & (~res_vld_q | rsp_ready);
  assign can_load = ~op_vld_q | adv;

  // Gated by reset so no requester sees a handshake while the pipeline is held.
  assign req_ready = (reset & can_load) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    op_vld_d  = op_vld_q;
    op_d      = op_q;
    op_id_d   = op_id_q;
    res_vld_d = res_vld_q;
    res_d     = res_q;
    res_id_d  = res_id_q;
    rr_ptr_d  = rr_ptr_q;

    // The operand stage may reload on the same edge it hands off to the
    // result stage, which keeps throughput at one op per cycle.
    if (accept) begin
      op_vld_d = 1'b1;
      op_d.a   = req_a[int'(winner)*ADD_W +: ADD_W];
      op_d.b   = req_b[int'(winner)*ADD_W +: ADD_W];
      op_id_d  = winner;
      rr_ptr_d = (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
    end else if (adv) begin
      op_vld_d = 1'b0;
    end

    if (adv) begin
      res_vld_d  = 1'b1;
      res_d.sum  = sum;
      res_d.cout = carry_out(op_q.a[ADD_W-1], op_q.b[ADD_W-1], sum[ADD_W-1]);
      res_id_d   = op_id_q;
    end else if (res_vld_q && rsp_ready) begin
      res_vld_d = 1'b0;
    end
  end

  // Data registers are reset too because rsp_* are driven straight from them
  // and must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_vld_q  <= 1'b0;
      op_q      <= '0;
      op_id_q   <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_id_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      op_vld_q  <= op_vld_d;
      op_q      <= op_d;
      op_id_q   <= op_id_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign rsp_valid = res_vld_q;
  assign rsp_id    = res_id_q;
  assign rsp_sum   = res_q.sum;
  assign rsp_cout  = res_q.cout;
  assign busy      = op_vld_q | res_vld_q;

endmodule

// File: tb/tb_ks8_add_arbiter.sv
// Scoreboard bench for ks8_add_arbiter: a transaction-level model predicts
// grants, pipeline occupancy and sums; a negedge monitor compares the DUT.
module tb_ks8_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
  logic              busy;

  always #5 clk = ~clk;

  ks8_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  typedef struct {
    int id;
    int sum;
    int cout;
    int edge_n;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   ptr_m    = 0;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) edge_cnt++;

  // Monitor: occupancy is the number of accepted-but-unconsumed ops; the oldest
  // becomes visible one edge after the edge that accepted it.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      int              n;
      int              w;
      int              a;
      int              b;
      logic            exp_valid;
      logic [NREQ-1:0] exp_ready;
      exp_t            e;
      n = sb.size();
      check("busy", busy, n > 0);
      exp_valid = (n > 0) && (sb[0].edge_n < edge_cnt);
      check("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rsp_id", rsp_id, sb[0].id);
        check("rsp_sum", rsp_sum, sb[0].sum);
        check("rsp_cout", rsp_cout, sb[0].cout);
        if (rsp_ready) void'(sb.pop_front());
      end
      w = model_winner(req_valid, ptr_m);
      exp_ready = '0;
      if (w >= 0 && (n < 2 || rsp_ready)) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      if (exp_ready != '0) begin
        a        = int'(req_a[w*8 +: 8]);
        b        = int'(req_b[w*8 +: 8]);
        e.id     = w;
        e.sum    = (a + b) % 256;
        e.cout   = (a + b) / 256;
        e.edge_n = edge_cnt + 1;
        sb.push_back(e);
        grant_log.push_back(w);
        ptr_m = (w + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom), 8'($urandom));
  endtask

  task automatic check_log(input string name, input int exp_ids[8], input int len);
    check({name, "_count"}, grant_log.size(), len);
    for (int i = 0; i < len; i++)
      if (i < grant_log.size()) check(name, grant_log[i], exp_ids[i]);
  endtask

  initial begin
    int rr_ids[8];
    int fair_ids[8];
    rr_ids   = '{0, 1, 2, 3, 0, 1, 2, 3};
    fair_ids = '{3, 1, 3, 1, 0, 0, 0, 0};

    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_busy", busy, 0);
    req_valid = '1;
    #1;
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    repeat (2) step();
    reset = 1'b1;

    // Single op from requester 0, then carry cases from requester 2.
    step(); set_req(0, 8'h0F, 8'h01); req_valid = 4'b0001; rsp_ready = 1'b1;
    step(); req_valid = '0;
    repeat (3) step();
    set_req(2, 8'hFF, 8'h01); req_valid = 4'b0100;
    step(); set_req(2, 8'h80, 8'h80);
    step(); set_req(3, 8'h7F, 8'h7F); req_valid = 4'b1000;
    step(); req_valid = '0;
    repeat (3) step();
    check("drain_directed", sb.size(), 0);

    // Round robin with everyone asking, one result per cycle.
    grant_log.delete();
    repeat (8) begin
      req_valid = '1; rand_ops();
      step();
    end
    req_valid = '0;
    repeat (3) step();
    check_log("rr_order", rr_ids, 8);
    check("drain_rr", sb.size(), 0);

    // Backpressure: two accepts fill the pipe, then everything must hold.
    grant_log.delete();
    rsp_ready = 1'b0; req_valid = '1; rand_ops();
    repeat (4) step();
    req_valid = '0;
    repeat (2) step();
    check("bp_busy", busy, 1);
    rsp_ready = 1'b1;
    repeat (3) step();
    check("drain_bp", sb.size(), 0);

    // Skipped requesters: pointer now sits at 2 with only 1 and 3 asking.
    grant_log.delete();
    repeat (4) begin
      req_valid = 4'b1010; rand_ops();
      step();
    end
    req_valid = '0;
    repeat (3) step();
    check_log("fair_order", fair_ids, 4);

    // Random traffic with random backpressure.
    repeat (400) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom % 10) < 7;
      rand_ops();
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) step();
    check("drain_rand", sb.size(), 0);

    // Reset with both stages occupied.
    rsp_ready = 1'b0; req_valid = '1; rand_ops();
    repeat (3) step();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", rsp_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_sum", rsp_sum, 0);
    sb.delete(); grant_log.delete(); ptr_m = 0;
    repeat (2) step();
    reset = 1'b1; rsp_ready = 1'b1;
    repeat (4) step();
    req_valid = '0;
    repeat (3) step();
    check("post_rst_grants", grant_log.size() > 0, 1);
    if (grant_log.size() > 0) check("post_rst_first", grant_log[0], 0);
    check("drain_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ks8_add_arbiter.md
Name: ks8_add_arbiter

Overview:
- Shares one kogg_stone_8 adder instance among NREQ requesters. Each requester supplies an 8-bit operand pair and receives the sum and a carry-out.
- Round-robin grant feeds a 2-stage pipeline: an operand register, then a result register. Valid/ready handshakes are used on both sides.
- Sits between multiple datapath clients and the single shared prefix adder. No client sees the adder directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester id; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; one clock.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  8*NREQ  operand A; slice i belongs to requester i.
- req_b  in  8*NREQ  operand B; slice i belongs to requester i.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester index that produced the result.
- rsp_sum  out  8  (a+b) mod 256.
- rsp_cout  out  1  carry-out: (a7&b7) | ((a7|b7)&~s7).
- busy  out  1  operand or result stage occupied.

Behaviour:
- Reset (reset=0, asynchronous):
  - op_vld=0, res_vld=0, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, req_ready=0.
- Arbitration (combinational):
  - The winner is the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[winner] = can_load; all other bits are 0.
  - No valid request means req_ready=0.
- can_load = ~op_vld | adv.
- adv = op_vld & (~res_vld | rsp_ready).
- Accept, when req_valid[w] & req_ready[w]:
  - Load op_a, op_b and op_id=w; set op_vld=1.
  - rr_ptr <= (w+1) mod NREQ.
  - rr_ptr holds when there is no accept, so it is not disturbed during a stall.
- Adder path:
  - op_a and op_b drive kogg_stone_8 combinationally.
  - On adv: res_sum <= s, res_cout <= the carry formula above, res_id <= op_id, res_vld <= 1.
- Drain: when res_vld & rsp_ready & ~adv, set res_vld <= 0.
- Latency and throughput:
  - An accept at edge N gives rsp_valid=1 after edge N+1.
  - Throughput is 1 op/cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0 and both stages full, req_ready=0 and all registers hold.
- Simultaneous load and advance: the op stage reloads on the same edge it advances. No bubble is inserted.
- Outputs: rsp_* are driven directly from the result registers. Values are stable while rsp_valid=1 & rsp_ready=0.
- busy = op_vld | res_vld.
- Reset mid-operation: in-flight ops are discarded, with no response. This is not an error.
- A requester dropping req_valid before its handshake is legal. The grant re-evaluates every cycle.

Decomposition:
- Shared package: NREQ_MAX=8, ADD_W=8, and the carry-out expression as a function.
- Sub-module rr_arbiter (NREQ): inputs req_valid and rr_ptr; outputs a one-hot grant and the encoded winner.
- The top level holds the pipeline registers and the kogg_stone_8 instance.

Test Plan:
- Reset and single op: after reset, check all outputs are 0. Req0 a=0x0F, b=0x01 -> one cycle later rsp_valid=1, id=0, sum=0x10, cout=0.
- Carry-out: req2 a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1.
- Round robin: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,… at 1 result per cycle.
- Backpressure: rsp_ready=0 with two ops accepted -> req_ready=0 and rsp_* held. Release rsp_ready -> results appear in order, none lost or duplicated.
- Fairness on skipped requesters: only req1 and req3 valid, rr_ptr=2 -> grants go 3,1,3,1.
- Reset mid-flight: assert reset with op_vld=1 and res_vld=1 -> rsp_valid=0 immediately (async), busy=0. The first post-reset grant goes to req0.
